// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - issue/writeback sequencer for the iterative multdiv unit
module multdiv_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int RD_W    = 5
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic            issue_is_div,
    input  logic [31:0]     issue_opA,
    input  logic [31:0]     issue_opB,
    input  logic [RD_W-1:0] issue_rd,
    input  logic            flush,
    output logic [31:0]     md_operandA,
    output logic [31:0]     md_operandB,
    output logic            md_ctrl_MULT,
    output logic            md_ctrl_DIV,
    input  logic [31:0]     md_result,
    input  logic            md_exception,
    input  logic            md_resultRDY,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            wb_exception
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BUSY  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             is_div_q;
    logic             timeout_hit;

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    // Saturating increment: the counter must never wrap back into a fresh budget.
    assign cnt_next    = (cnt == CNT_W'(TIMEOUT)) ? cnt : cnt + CNT_W'(1);

    assign issue_ready  = (state == S_IDLE);
    assign md_ctrl_MULT = (state == S_START) && !is_div_q;
    assign md_ctrl_DIV  = (state == S_START) && is_div_q;
    assign wb_valid     = (state == S_DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            is_div_q     <= 1'b0;
            md_operandA  <= '0;
            md_operandB  <= '0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_exception <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue_valid && !flush) begin
                        md_operandA <= issue_opA;
                        md_operandB <= issue_opB;
                        is_div_q    <= issue_is_div;
                        wb_rd       <= issue_rd;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    // Any resultRDY seen here belongs to a previous operation.
                    cnt   <= '0;
                    state <= flush ? S_DRAIN : S_BUSY;
                end
                S_BUSY: begin
                    cnt <= cnt_next;
                    if (flush) begin
                        state <= S_DRAIN;
                    end else if (md_resultRDY) begin
                        wb_data      <= md_exception ? 32'd0 : md_result;
                        wb_exception <= md_exception;
                        state        <= S_DONE;
                    end else if (timeout_hit) begin
                        wb_data      <= 32'd0;
                        wb_exception <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DRAIN: begin
                    // The unit cannot be aborted, so let it finish before reissuing.
                    cnt <= cnt_next;
                    if (md_resultRDY || timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (flush || wb_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - directed self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic        issue_is_div = 1'b0;
    logic [31:0] issue_opA = '0;
    logic [31:0] issue_opB = '0;
    logic [4:0]  issue_rd = '0;
    logic        flush = 1'b0;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_resultRDY = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    int errors = 0;
    int checks = 0;

    int md_lat  = 33;
    bit md_stub = 1'b0;
    bit md_on   = 1'b0;
    int md_cnt  = 0;

    int mult_cnt = 0;
    int div_cnt  = 0;
    int both_hi  = 0;

    multdiv_sequencer #(.TIMEOUT(40), .RD_W(5)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_is_div (issue_is_div),
        .issue_opA    (issue_opA),
        .issue_opB    (issue_opB),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_ctrl_MULT (md_ctrl_MULT),
        .md_ctrl_DIV  (md_ctrl_DIV),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_exception (wb_exception)
    );

    always #5 clock = ~clock;

    // Behavioural multdiv: raises resultRDY for one cycle md_lat cycles after the start pulse.
    always @(posedge clock) begin
        #2;
        md_resultRDY = 1'b0;
        if (md_on) begin
            if (md_cnt == 0) begin
                md_resultRDY = 1'b1;
                md_on = 1'b0;
            end else begin
                md_cnt--;
            end
        end
        if (md_ctrl_MULT || md_ctrl_DIV) begin
            if (md_ctrl_DIV) begin
                if (md_operandB == 32'd0) begin
                    md_exception = 1'b1;
                    md_result = 32'hDEADBEEF;
                end else begin
                    md_exception = 1'b0;
                    md_result = md_operandA / md_operandB;
                end
            end else begin
                md_exception = 1'b0;
                md_result = md_operandA * md_operandB;
            end
            if (!md_stub) begin
                md_on = 1'b1;
                md_cnt = md_lat - 1;
            end
        end
    end

    always @(negedge clock) begin
        if (md_ctrl_MULT) mult_cnt++;
        if (md_ctrl_DIV) div_cnt++;
        if (md_ctrl_MULT && md_ctrl_DIV) both_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_issue(input logic [31:0] a, input logic [31:0] b,
                            input logic div, input logic [4:0] rd);
        issue_valid  = 1'b1;
        issue_opA    = a;
        issue_opB    = b;
        issue_is_div = div;
        issue_rd     = rd;
        @(negedge clock);
        issue_valid  = 1'b0;
    endtask

    task automatic wait_wb(input int max_cycles, output int waited,
                           output logic prev_rdy, output int ready_hi);
        waited = 0;
        prev_rdy = 1'b0;
        ready_hi = 0;
        while (!wb_valid && waited < max_cycles) begin
            prev_rdy = md_resultRDY;
            if (issue_ready) ready_hi++;
            @(negedge clock);
            waited++;
        end
        chk("wb_valid_within_bound", {31'd0, wb_valid}, 32'd1);
    endtask

    task automatic wb_handshake;
        wb_ready = 1'b1;
        @(negedge clock);
        wb_ready = 1'b0;
    endtask

    initial begin
        int   waited;
        int   ready_hi;
        int   bad;
        int   first_hi;
        int   wbv;
        int   rdy_seen;
        logic prev_rdy;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
        chk("rst_operandA", md_operandA, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // MULT 7 * -3
        md_lat = 33;
        mult_cnt = 0;
        div_cnt = 0;
        do_issue(32'd7, 32'hFFFFFFFD, 1'b0, 5'd5);
        chk("mult_start_pulse", {31'd0, md_ctrl_MULT}, 32'd1);
        chk("mult_start_ready", {31'd0, issue_ready}, 32'd0);
        chk("mult_operandB", md_operandB, 32'hFFFFFFFD);
        wait_wb(100, waited, prev_rdy, ready_hi);
        chk("mult_latency", waited, 32'd34);
        chk("mult_rdy_prev_cycle", {31'd0, prev_rdy}, 32'd1);
        chk("mult_ready_low", ready_hi, 32'd0);
        chk("mult_data", wb_data, 32'hFFFFFFEB);
        chk("mult_exc", {31'd0, wb_exception}, 32'd0);
        chk("mult_rd", {27'd0, wb_rd}, 32'd5);
        chk("mult_pulses", mult_cnt, 32'd1);
        chk("mult_no_div", div_cnt, 32'd0);
        wb_handshake();
        chk("mult_wb_drop", {31'd0, wb_valid}, 32'd0);
        chk("mult_idle", {31'd0, issue_ready}, 32'd1);

        // DIV 100 / 7 then back-to-back DIV 5 / 0
        mult_cnt = 0;
        div_cnt = 0;
        do_issue(32'd100, 32'd7, 1'b1, 5'd9);
        wait_wb(100, waited, prev_rdy, ready_hi);
        chk("div_data", wb_data, 32'd14);
        chk("div_exc", {31'd0, wb_exception}, 32'd0);
        chk("div_rd", {27'd0, wb_rd}, 32'd9);
        chk("div_ready_low", ready_hi, 32'd0);
        wb_handshake();
        do_issue(32'd5, 32'd0, 1'b1, 5'd10);
        wait_wb(100, waited, prev_rdy, ready_hi);
        chk("div0_data", wb_data, 32'd0);
        chk("div0_exc", {31'd0, wb_exception}, 32'd1);
        chk("div0_rd", {27'd0, wb_rd}, 32'd10);
        chk("div0_ready_low", ready_hi, 32'd0);
        chk("div_pulses", div_cnt, 32'd2);
        chk("div_no_mult", mult_cnt, 32'd0);
        wb_handshake();

        // Stub never answers: watchdog completion
        md_stub = 1'b1;
        do_issue(32'd1, 32'd2, 1'b0, 5'd7);
        wait_wb(60, waited, prev_rdy, ready_hi);
        chk("timeout_latency", waited, 32'd41);
        chk("timeout_data", wb_data, 32'd0);
        chk("timeout_exc", {31'd0, wb_exception}, 32'd1);
        chk("timeout_rd", {27'd0, wb_rd}, 32'd7);
        wb_handshake();
        md_stub = 1'b0;

        // Flush in BUSY cycle 10; RDY arrives 20 cycles after the start pulse
        md_lat = 20;
        do_issue(32'd50, 32'd60, 1'b0, 5'd8);
        first_hi = 0;
        wbv = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            flush = (k == 11);
            if (wb_valid) wbv++;
            if (issue_ready && first_hi == 0) first_hi = k;
        end
        flush = 1'b0;
        chk("flush_no_wb", wbv, 32'd0);
        chk("flush_ready_return", first_hi, 32'd21);

        // Writeback back-pressure, then accept on the cycle after the handshake
        md_lat = 5;
        do_issue(32'd6, 32'd7, 1'b0, 5'd3);
        wait_wb(40, waited, prev_rdy, ready_hi);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (wb_valid !== 1'b1 || wb_data !== 32'd42 || wb_rd !== 5'd3 || issue_ready !== 1'b0)
                bad++;
            @(negedge clock);
        end
        chk("stall_stable", bad, 32'd0);
        wb_ready = 1'b1;
        issue_valid = 1'b1;
        issue_opA = 32'd2;
        issue_opB = 32'd3;
        issue_is_div = 1'b0;
        issue_rd = 5'd4;
        @(negedge clock);
        wb_ready = 1'b0;
        chk("b2b_wb_drop", {31'd0, wb_valid}, 32'd0);
        chk("b2b_idle", {31'd0, issue_ready}, 32'd1);
        @(negedge clock);
        issue_valid = 1'b0;
        chk("b2b_accepted", {31'd0, issue_ready}, 32'd0);
        chk("b2b_operandA", md_operandA, 32'd2);
        wait_wb(40, waited, prev_rdy, ready_hi);
        chk("b2b_data", wb_data, 32'd6);
        chk("b2b_rd", {27'd0, wb_rd}, 32'd4);

        // Flush in DONE beats wb_ready
        flush = 1'b1;
        wb_ready = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        wb_ready = 1'b0;
        chk("done_flush_wb", {31'd0, wb_valid}, 32'd0);
        chk("done_flush_idle", {31'd0, issue_ready}, 32'd1);

        // Flush blocks acceptance in IDLE
        flush = 1'b1;
        issue_valid = 1'b1;
        issue_opA = 32'd99;
        @(negedge clock);
        flush = 1'b0;
        issue_valid = 1'b0;
        chk("idle_flush_ready", {31'd0, issue_ready}, 32'd1);
        chk("idle_flush_operandA", md_operandA, 32'd2);

        // Asynchronous reset in BUSY cycle 15; the late RDY must be ignored
        md_lat = 33;
        do_issue(32'd3, 32'd4, 1'b0, 5'd12);
        for (int k = 1; k <= 16; k++) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("arst_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("arst_operandA", md_operandA, 32'd0);
        chk("arst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("arst_wb_data", wb_data, 32'd0);
        chk("arst_wb_exc", {31'd0, wb_exception}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        wbv = 0;
        rdy_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (wb_valid) wbv++;
            if (md_resultRDY) rdy_seen++;
        end
        chk("arst_late_rdy_seen", rdy_seen, 32'd1);
        chk("arst_no_wb", wbv, 32'd0);
        chk("arst_idle", {31'd0, issue_ready}, 32'd1);
        chk("ctrl_never_both", both_hi, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
